// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: oversampled start detect, 8N/E/O data, 1-4 stop bits
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_uart,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] parity_mode,
  input  logic [1:0] stop_bit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic          rx_d_q, rx_d_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    pmode_q, pmode_d;
  logic [1:0]    nstop_q, nstop_d;
  logic [7:0]    data_sh_q, data_sh_d;
  logic          xor_q, xor_d;
  logic          perr_sh_q, perr_sh_d;
  logic          ferr_sh_q, ferr_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_busy_q, rx_busy_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;

  logic fall;
  logic tick_hit;
  logic par_en;
  logic par_exp;
  logic stop_done;

  assign fall      = rx_d_q & ~rx_s_q;
  // START samples at mid-bit; every other sample is a full bit period later
  assign tick_hit  = (state_q == S_START) ? (tick_q == TICK_HALF) : (tick_q == TICK_LAST);
  assign par_en    = (pmode_q == 2'd1) || (pmode_q == 2'd2);
  assign par_exp   = (pmode_q == 2'd2) ? ~xor_q : xor_q;
  assign stop_done = (state_q == S_STOP) && tick_hit && (bit_q == {1'b0, nstop_q});

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (tick_hit) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick_hit && (bit_q == 3'd7)) state_d = par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (tick_hit) state_d = S_STOP;
      end
      S_STOP: begin
        if (stop_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    rx_d_d       = rx_s_q;
    tick_d       = ((state_q == S_IDLE) || tick_hit) ? '0 : tick_q + TW'(1);
    bit_d        = bit_q;
    pmode_d      = pmode_q;
    nstop_d      = nstop_q;
    data_sh_d    = data_sh_q;
    xor_d        = xor_q;
    perr_sh_d    = perr_sh_q;
    ferr_sh_d    = ferr_sh_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_busy_d    = rx_busy_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          pmode_d   = parity_mode;
          nstop_d   = stop_bit;
          data_sh_d = '0;
          xor_d     = 1'b0;
          perr_sh_d = 1'b0;
          ferr_sh_d = 1'b0;
          bit_d     = '0;
          rx_busy_d = 1'b1;
        end
      end
      S_START: begin
        if (tick_hit && rx_s_q) rx_busy_d = 1'b0;
      end
      S_DATA: begin
        if (tick_hit) begin
          data_sh_d[bit_q] = rx_s_q;
          xor_d            = xor_q ^ rx_s_q;
          // wraps to 0 after bit 7, ready to count stop bits
          bit_d            = bit_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (tick_hit) perr_sh_d = (rx_s_q != par_exp);
      end
      S_STOP: begin
        if (tick_hit) begin
          if (!rx_s_q) ferr_sh_d = 1'b1;
          bit_d = bit_q + 3'd1;
        end
        if (stop_done) begin
          bit_d        = '0;
          rx_data_d    = data_sh_q;
          parity_err_d = perr_sh_q;
          frame_err_d  = ferr_sh_q | ~rx_s_q;
          rx_valid_d   = 1'b1;
          rx_busy_d    = 1'b0;
        end
      end
      default: begin
        rx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      tick_q       <= '0;
      bit_q        <= '0;
      pmode_q      <= '0;
      nstop_q      <= '0;
      data_sh_q    <= '0;
      xor_q        <= 1'b0;
      perr_sh_q    <= 1'b0;
      ferr_sh_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_busy_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_d_q       <= rx_d_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      pmode_q      <= pmode_d;
      nstop_q      <= nstop_d;
      data_sh_q    <= data_sh_d;
      xor_q        <= xor_d;
      perr_sh_q    <= perr_sh_d;
      ferr_sh_q    <= ferr_sh_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_busy_q    <= rx_busy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_busy    = rx_busy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx
module tb_uart_rx;
  localparam int OS = 16;

  logic       clk_uart = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] parity_mode = 2'd0;
  logic [1:0] stop_bit = 2'd0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcount = 0;
  int last_valid_cyc = 0;
  int fall_cyc = 0;
  logic [9:0] vq[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic [1:0] sb;
    logic       pbit;
    logic [3:0] stops;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk_uart   (clk_uart),
    .rst        (rst),
    .rx         (rx),
    .parity_mode(parity_mode),
    .stop_bit   (stop_bit),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk_uart = ~clk_uart;

  always @(posedge clk_uart) cyc <= cyc + 1;

  always @(negedge clk_uart) begin
    if (rx_valid) begin
      vcount         <= vcount + 1;
      last_valid_cyc <= cyc;
      vq.push_back({parity_err, frame_err, rx_data});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) @(negedge clk_uart);
  endtask

  // Config is scrambled after the start bit so only the latched copy can be right
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic [1:0] sb,
                            input logic pbit, input logic [3:0] stops);
    parity_mode = pm;
    stop_bit    = sb;
    fall_cyc    = cyc;
    drive_bit(1'b0);
    parity_mode = ~pm;
    stop_bit    = ~sb;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pm == 2'd1 || pm == 2'd2) drive_bit(pbit);
    for (int k = 0; k <= int'(sb); k++) drive_bit(stops[k]);
    rx          = 1'b1;
    parity_mode = pm;
    stop_bit    = sb;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int lat;
    logic [9:0] e0;
    logic [9:0] e1;

    vecs[0] = '{8'hA5, 2'd0, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 2'd1, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 2'd1, 2'd0, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 2'd2, 2'd1, 1'b1, 4'b0001, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 2'd3, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 2'd0, 2'd3, 1'b0, 4'b1111, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 2'd2, 2'd2, 1'b1, 4'b0111, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 2'd2, 2'd3, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[8] = '{8'hC3, 2'd2, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk_uart);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk_uart);

    for (int i = 0; i < 9; i++) begin
      base = vcount;
      send_frame(vecs[i].data, vecs[i].pm, vecs[i].sb, vecs[i].pbit, vecs[i].stops);
      repeat (4) @(negedge clk_uart);
      check($sformatf("v%0d_strobes", i), vcount - base, 1);
      check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].data);
      check($sformatf("v%0d_parity_err", i), parity_err, vecs[i].exp_perr);
      check($sformatf("v%0d_frame_err", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("v%0d_busy_after", i), rx_busy, 1'b0);
      if (i == 0) begin
        lat = last_valid_cyc - fall_cyc;
        if (lat < 154 || lat > 156) check("valid_latency", lat, 155);
        else check("valid_latency_in_window", lat >= 154 && lat <= 156, 1'b1);
      end
      repeat (20) @(negedge clk_uart);
    end

    // Reset during data bit 4 of 0x81; previous frame left C3 with both errors set
    base = vcount;
    parity_mode = 2'd0;
    stop_bit    = 2'd0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk_uart);
    rst = 1'b0;
    #1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_rx_busy", rx_busy, 1'b0);
    check("midrst_parity_err", parity_err, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk_uart);
    rst = 1'b1;
    repeat (200) @(negedge clk_uart);
    check("midrst_no_strobe", vcount - base, 0);
    send_frame(8'h81, 2'd0, 2'd0, 1'b0, 4'b0001);
    repeat (4) @(negedge clk_uart);
    check("after_rst_strobes", vcount - base, 1);
    check("after_rst_rx_data", rx_data, 8'h81);
    check("after_rst_errs", {parity_err, frame_err}, 2'b00);
    repeat (20) @(negedge clk_uart);

    // Four-cycle glitch: false start
    base = vcount;
    rx = 1'b0;
    repeat (4) @(negedge clk_uart);
    rx = 1'b1;
    @(negedge clk_uart);
    check("glitch_busy_high", rx_busy, 1'b1);
    repeat (7) @(negedge clk_uart);
    check("glitch_busy_low", rx_busy, 1'b0);
    repeat (20) @(negedge clk_uart);
    check("glitch_no_strobe", vcount - base, 0);

    // Back-to-back frames, no idle gap
    base = vcount;
    send_frame(8'h55, 2'd0, 2'd0, 1'b0, 4'b0001);
    send_frame(8'hAA, 2'd0, 2'd0, 1'b0, 4'b0001);
    repeat (4) @(negedge clk_uart);
    check("b2b_strobes", vcount - base, 2);
    if (vq.size() >= 2) begin
      e0 = vq[vq.size() - 2];
      e1 = vq[vq.size() - 1];
    end else begin
      e0 = '0;
      e1 = '0;
    end
    check("b2b_first", e0, {2'b00, 8'h55});
    check("b2b_second", e1, {2'b00, 8'hAA});
    repeat (20) @(negedge clk_uart);

    // Break: line held low yields one frame with frame_err, then nothing
    base = vcount;
    rx = 1'b0;
    repeat (400) @(negedge clk_uart);
    check("break_strobes", vcount - base, 1);
    check("break_rx_data", rx_data, 8'h00);
    check("break_frame_err", frame_err, 1'b1);
    check("break_parity_err", parity_err, 1'b0);
    check("break_busy", rx_busy, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk_uart);
    check("break_release_no_strobe", vcount - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
